// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: drives TAP tms/tdi for DR/IR scans and TAP reset sequences,
// capturing tdo into a right-aligned response word held until the consumer takes it.
module jtag_scan_sequencer (
    input  logic        tck,
    input  logic        trst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_reset,
    input  logic        cmd_ir,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo,
    output logic        busy
);
    localparam logic [3:0] INIT     = 4'd0;
    localparam logic [3:0] IDLE     = 4'd1;
    localparam logic [3:0] SEL_DR   = 4'd2;
    localparam logic [3:0] SEL_IR   = 4'd3;
    localparam logic [3:0] CAPTURE  = 4'd4;
    localparam logic [3:0] SHIFT    = 4'd5;
    localparam logic [3:0] EXIT1    = 4'd6;
    localparam logic [3:0] UPDATE   = 4'd7;
    localparam logic [3:0] WAIT_RSP = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d, last_q, last_d;
    logic        ir_q, ir_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [31:0] data_q, data_d, rsp_q, rsp_d;
    logic        accept;

    assign cmd_ready = state_q == IDLE;
    assign rsp_valid = state_q == WAIT_RSP;
    assign busy      = state_q != IDLE;
    assign rsp_data  = rsp_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        last_d  = last_q;
        ir_d    = ir_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        case (state_q)
            INIT: state_d = (cnt_q == 5'd5) ? IDLE : INIT;
            IDLE: begin
                cnt_d = 5'd0;
                if (accept) begin
                    state_d = cmd_reset ? INIT : SEL_DR;
                    if (!cmd_reset) begin
                        ir_d   = cmd_ir;
                        data_d = cmd_data;
                        rsp_d  = 32'd0;
                        last_d = (cmd_len == 6'd0) ? 5'd0 : (cmd_len > 6'd32) ? 5'd31 : 5'(cmd_len - 6'd1);
                    end
                end
            end
            SEL_DR: begin
                state_d = ir_q ? SEL_IR : CAPTURE;
                cnt_d   = 5'd0;
            end
            SEL_IR: begin
                state_d = CAPTURE;
                cnt_d   = 5'd0;
            end
            // two tms=0 cycles: Select -> Capture, then Capture -> Shift
            CAPTURE: begin
                state_d = (cnt_q == 5'd1) ? SHIFT : CAPTURE;
                cnt_d   = (cnt_q == 5'd1) ? 5'd0 : cnt_q + 5'd1;
            end
            SHIFT: begin
                rsp_d[cnt_q] = tdo;
                state_d      = (cnt_q == last_q) ? EXIT1 : SHIFT;
            end
            EXIT1:    state_d = UPDATE;
            UPDATE:   state_d = WAIT_RSP;
            WAIT_RSP: state_d = rsp_ready ? IDLE : WAIT_RSP;
            default: begin
                state_d = INIT;
                cnt_d   = 5'd0;
            end
        endcase
        // pins are registered copies of the value belonging to the upcoming cycle
        tms_d = (state_d == INIT) ? (cnt_d != 5'd5) :
                (state_d == SEL_DR || state_d == SEL_IR || state_d == EXIT1) ? 1'b1 :
                (state_d == SHIFT) ? (cnt_d == last_d) : 1'b0;
        tdi_d = (state_d == SHIFT) && data_d[cnt_d];
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= INIT;
            cnt_q   <= 5'd0;
            last_q  <= 5'd0;
            ir_q    <= 1'b0;
            data_q  <= 32'd0;
            rsp_q   <= 32'd0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ir_q    <= ir_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: directed and randomized scans checked every cycle against a
// queue-based model of the expected tms/tdi waveform and captured response.
module tb_jtag_scan_sequencer;
    logic        tck = 1'b0, trst = 1'b1, cmd_valid = 1'b0, cmd_reset = 1'b0, cmd_ir = 1'b0;
    logic        rsp_ready = 1'b0, tdo = 1'b0, rand_tdo = 1'b0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready, rsp_valid, tms, tdi, busy;
    logic [31:0] rsp_data;
    int          checks = 0, errors = 0;

    typedef struct { logic tms; logic tdi; int idx; } step_t;
    step_t       q[$];
    bit          m_wait = 0, m_scan = 0;
    logic [31:0] m_rsp = 32'd0;

    jtag_scan_sequencer dut (
        .tck(tck), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_reset(cmd_reset), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
    );

    always #5 tck = ~tck;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic t, input logic d, input int i);
        step_t s;
        s.tms = t;
        s.tdi = d;
        s.idx = i;
        q.push_back(s);
    endtask

    // expected per-cycle waveform built straight from the scan rules
    task automatic load(input bit rst, input bit ir, input logic [5:0] len, input logic [31:0] d);
        int n;
        n = (len == 0) ? 1 : (len > 32) ? 32 : int'(len);
        q.delete();
        if (rst) begin
            for (int k = 0; k < 6; k++) push(k < 5, 1'b0, -1);
            m_scan = 0;
        end else begin
            push(1'b1, 1'b0, -1);
            if (ir) push(1'b1, 1'b0, -1);
            push(1'b0, 1'b0, -1);
            push(1'b0, 1'b0, -1);
            for (int i = 0; i < n; i++) push(i == n - 1, d[i], i);
            push(1'b1, 1'b0, -1);
            push(1'b0, 1'b0, -1);
            m_scan = 1;
            m_rsp  = 32'd0;
        end
    endtask

    always @(negedge tck) begin : compare
        step_t s;
        if (trst) begin
            chk("rst_tms", tms, 1);
            chk("rst_tdi", tdi, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_busy", busy, 1);
            load(1, 0, 6'd0, 32'd0);
            m_wait = 0;
        end else if (q.size() > 0) begin
            s = q.pop_front();
            chk("seq_tms", tms, s.tms);
            chk("seq_tdi", tdi, s.tdi);
            chk("seq_busy", busy, 1);
            chk("seq_cmd_ready", cmd_ready, 0);
            chk("seq_rsp_valid", rsp_valid, 0);
            if (s.idx >= 0) m_rsp[s.idx] = tdo;
            if (q.size() == 0 && m_scan) m_wait = 1;
        end else if (m_wait) begin
            chk("wait_rsp_valid", rsp_valid, 1);
            chk("wait_rsp_data", rsp_data, m_rsp);
            chk("wait_cmd_ready", cmd_ready, 0);
            chk("wait_busy", busy, 1);
            chk("wait_tms", tms, 0);
            chk("wait_tdi", tdi, 0);
            if (rsp_ready) m_wait = 0;
        end else begin
            chk("idle_cmd_ready", cmd_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_tms", tms, 0);
            chk("idle_tdi", tdi, 0);
            if (cmd_valid) load(cmd_reset, cmd_ir, cmd_len, cmd_data);
        end
    end

    always @(posedge tck) begin
        #1;
        if (rand_tdo) tdo = 1'($urandom);
    end

    task automatic cyc();
        @(posedge tck);
        #1;
    endtask

    task automatic send(input bit rst, input bit ir, input logic [5:0] len, input logic [31:0] d);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_reset = rst;
        cmd_ir    = ir;
        cmd_len   = len;
        cmd_data  = d;
        while (!cmd_ready && g < 200) begin
            cyc();
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", g);
        end
        cyc();
        cmd_valid = 1'b0;
        cmd_reset = 1'($urandom);
        cmd_ir    = 1'($urandom);
        cmd_len   = 6'($urandom);
        cmd_data  = $urandom;
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!cmd_ready && g < 200) begin
            cyc();
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready stayed 0 for %0d cycles", g);
        end
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!rsp_valid && g < 200) begin
            rsp_ready = 1'($urandom);
            cyc();
            g++;
        end
        rsp_ready = 1'b0;
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0 for %0d cycles", g);
        end
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic run_trace(input int ncyc, input logic [31:0] pat, input int ss,
                             output logic [63:0] tms_tr, output logic [63:0] tdi_tr,
                             output logic [63:0] rv_tr);
        tms_tr = 64'd0;
        tdi_tr = 64'd0;
        rv_tr  = 64'd0;
        for (int k = 0; k < ncyc; k++) begin
            tdo       = (k >= ss && k - ss < 32) ? pat[k - ss] : 1'b0;
            tms_tr[k] = tms;
            tdi_tr[k] = tdi;
            rv_tr[k]  = rsp_valid;
            cyc();
        end
        tdo = 1'b0;
    endtask

    initial begin
        logic [63:0] tt, dt, vt;
        repeat (3) cyc();
        trst = 1'b0;
        run_trace(6, 32'd0, 99, tt, dt, vt);
        chk("init_tms_seq", tt, 64'h1F);
        chk("init_tdi_seq", dt, 64'h0);
        chk("init_ready_c7", cmd_ready, 1);

        send(0, 0, 6'd8, 32'hA5);
        run_trace(13, 32'h3C, 3, tt, dt, vt);
        chk("dr8_tms_seq", tt, 64'h0C01);
        chk("dr8_tdi_seq", dt, 64'h528);
        chk("dr8_rsp_valid", rsp_valid, 1);
        chk("dr8_rsp_data", rsp_data, 32'h3C);
        for (int k = 0; k < 5; k++) begin
            cmd_valid = (k == 2);
            cyc();
            chk("hold_rsp_data", rsp_data, 32'h3C);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        take();
        chk("take_cmd_ready", cmd_ready, 1);
        chk("take_rsp_valid", rsp_valid, 0);

        send(0, 1, 6'd4, 32'h9);
        run_trace(10, 32'h6, 4, tt, dt, vt);
        chk("ir4_tms_seq", tt, 64'h183);
        chk("ir4_tdi_seq", dt, 64'h90);
        chk("ir4_rsp_valid", rsp_valid, 1);
        chk("ir4_rsp_data", rsp_data, 32'h6);
        take();

        send(0, 0, 6'd0, 32'hFFFF_FFFF);
        run_trace(6, 32'h1, 3, tt, dt, vt);
        chk("len0_tms_seq", tt, 64'h19);
        chk("len0_tdi_seq", dt, 64'h8);
        chk("len0_no_early_valid", vt, 64'h0);
        chk("len0_rsp_valid", rsp_valid, 1);
        chk("len0_rsp_data", rsp_data, 32'h1);
        take();

        send(0, 0, 6'd40, 32'h1234_5678);
        run_trace(37, 32'hDEAD_BEEF, 3, tt, dt, vt);
        chk("len40_tms_seq", tt, 64'hC_0000_0001);
        chk("len40_tdi_seq", dt, 64'h9_1A2B_3C0);
        chk("len40_no_early_valid", vt, 64'h0);
        chk("len40_rsp_valid", rsp_valid, 1);
        chk("len40_rsp_data", rsp_data, 32'hDEAD_BEEF);
        take();

        send(1, 1, 6'd20, 32'hFFFF);
        run_trace(6, 32'hFFFF_FFFF, 0, tt, dt, vt);
        chk("rstcmd_tms_seq", tt, 64'h1F);
        chk("rstcmd_tdi_seq", dt, 64'h0);
        chk("rstcmd_no_rsp", vt, 64'h0);
        chk("rstcmd_ready", cmd_ready, 1);

        send(0, 0, 6'd16, 32'hBEEF);
        run_trace(6, 32'hFFFF, 3, tt, dt, vt);
        trst = 1'b1;
        cyc();
        trst = 1'b0;
        run_trace(6, 32'd0, 99, tt, dt, vt);
        chk("abort_init_tms", tt, 64'h1F);
        chk("abort_no_rsp", vt, 64'h0);
        chk("abort_ready", cmd_ready, 1);
        send(0, 0, 6'd5, 32'h15);
        run_trace(10, 32'hA, 3, tt, dt, vt);
        chk("after_abort_rsp", rsp_data, 32'hA);
        chk("after_abort_valid", rsp_valid, 1);
        take();

        rand_tdo = 1'b1;
        for (int it = 0; it < 80; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send(1, 1'($urandom), 6'($urandom), $urandom);
                wait_ready();
            end else begin
                send(0, 1'($urandom), 6'($urandom_range(0, 40)), $urandom);
                if (kind == 1) begin
                    repeat ($urandom_range(0, 40)) cyc();
                    trst = 1'b1;
                    cyc();
                    trst = 1'b0;
                    wait_ready();
                end else begin
                    wait_valid();
                    repeat ($urandom_range(0, 3)) cyc();
                    take();
                end
            end
        end
        rand_tdo = 1'b0;
        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
